pulse_hs_sync_multi: RTL and testbench
======================================

Name: pulse_hs_sync_multi

Overview:
- Parametrised, multi-channel successor to the team's single-channel toggle pulse synchroniser.
- Each channel carries single-cycle src_clk pulses to single-cycle dst_clk pulses with a toggle req/ack handshake.
- Pulses arriving while a transfer is in flight are queued in a per-channel saturating counter instead of being lost; a sticky overflow flag reports drops.
- Used for event/interrupt crossings where pulse rate can exceed the crossing rate.

Parameters:
- NUM_CH, 4: number of independent channels.
- SYNC_STAGES, 2: flops per synchroniser chain in both directions; legal range 2..4.
- CNT_W, 3: pending-counter width; queue depth is 2^CNT_W-1.

Ports:
- src_clk  in  1  source clock
- src_rst_n  in  1  source reset
- dst_clk  in  1  destination clock
- dst_rst_n  in  1  destination reset, asynchronous, active-low
- src_pulse  in  NUM_CH  per-channel event, one src_clk cycle per event
- src_ovf_clr  in  NUM_CH  clears src_ovf bit (src_clk)
- src_busy  out  NUM_CH  transfer in flight or pulses pending
- src_ovf  out  NUM_CH  sticky: a pulse was dropped
- dst_pulse  out  NUM_CH  registered one-cycle pulse per delivered event

Interface decisions:
- Reset src_rst_n, asynchronous, active-low; clock src_clk.
- All src_* ports are synchronous to src_clk. dst_pulse is synchronous to dst_clk.

Behaviour:

Per-channel source state (src_clk domain):
- req_tgl, pend_cnt[CNT_W], ack_sync chain (SYNC_STAGES), ovf.
- idle = (req_tgl == ack_sync last stage).
- Launch condition: idle and (pend_cnt>0 or src_pulse).
  - On launch, req_tgl inverts.
  - If pend_cnt>0: pend_cnt <= pend_cnt - 1 + src_pulse (simultaneous pulse and launch leaves the count unchanged).
  - Otherwise the pulse is launched directly and the count stays 0.
- Not launching with src_pulse=1:
  - pend_cnt increments if below max.
  - If pend_cnt is at max, the pulse is dropped and ovf <= 1.
- src_ovf_clr=1 clears ovf; a same-cycle drop wins (ovf stays 1).
- src_busy = !idle or pend_cnt != 0. This is combinational from registers; no src_pulse term.

Per-channel destination state (dst_clk domain):
- req_sync chain (SYNC_STAGES), req_d.
- dst_pulse <= req_sync_last ^ req_d; req_d <= req_sync_last.
- ack_tgl is req_d, i.e. it toggles in the same cycle dst_pulse is registered high.

Latency:
- dst_pulse rises SYNC_STAGES+1 dst_clk edges after the first dst edge that samples the new req_tgl (±1 cycle of metastability uncertainty).
- ack reaches idle SYNC_STAGES src_clk edges after it is sampled.
- Minimum per-transfer period: about SYNC_STAGES+2 cycles of each clock.

Ordering and channel independence:
- Events are delivered per channel in order, one dst_pulse per accepted src_pulse.
- Channels are fully independent; there are no cross-channel relations between outputs.

Reset values:
- src_rst_n low: req_tgl, pend_cnt, ack_sync, ovf all 0, so src_busy=0 and src_ovf=0.
- dst_rst_n low: req_sync, req_d, dst_pulse all 0, so ack_tgl=0.

Reset mid-operation:
- dst-only reset with req_tgl=1: after release, one dst_pulse is emitted for the in-flight event; the handshake stays consistent.
- src-only reset: pending and in-flight events are discarded. The system must assert dst_rst_n whenever src_rst_n is asserted, otherwise ack_tgl=1 and req_tgl=0 hold src_busy high until dst reset.
- The bench checks the combined-reset case only; src-only reset is documented as illegal.

CDC constraints:
- Only req_tgl and ack_tgl cross domains, each a single bit from a flop.
- Synchroniser flops carry the team's async-reg attribute.

Decomposition:
- Shared package (cdc_pkg) holds:
  - SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4
  - parameter-check function
  - default constants
- Natural sub-module: pulse_hs_chan, one channel with both domain halves.
- Top level is a generate loop over NUM_CH plus parameter elaboration checks.

Test Plan (NUM_CH=2, SYNC_STAGES=2, CNT_W=2, src 100 MHz, dst 37 MHz unless stated):
- Single pulse on ch0 -> exactly one dst_pulse[0] 3–4 dst cycles after req toggle; src_busy[0] returns to 0; ch1 silent.
- 3 back-to-back src_pulse[0] cycles -> first launched directly, pend_cnt 2; exactly 3 dst_pulse[0], src_busy low after the last ack; src_ovf=0.
- 5 back-to-back pulses with queue depth 3 -> 4 delivered (1 in flight + 3 queued), src_ovf[0]=1; clear with src_ovf_clr -> 0.
- Same-cycle clear and drop -> src_ovf stays 1.
- Pulse coincident with launch at pend_cnt=1 -> count stays 1, total deliveries correct.
- Clock ratios 1:5 and 5:1 with random pulses on both channels -> scoreboard count match per channel, no dst_pulse wider than 1 cycle.
- Assert both resets during an in-flight transfer -> all outputs 0 within reset; after release no spurious dst_pulse, and new pulses are delivered normally.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared CDC constants and elaboration-time parameter checks for the pulse handshake
// synchronisers.
`timescale 1ns/1ps
package cdc_pkg;

  localparam int unsigned SYNC_STAGES_MIN     = 2;
  localparam int unsigned SYNC_STAGES_MAX     = 4;

  localparam int unsigned NUM_CH_DEFAULT      = 4;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned CNT_W_DEFAULT       = 3;

  function automatic bit sync_stages_ok(input int unsigned stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

  function automatic bit sync_params_ok(input int unsigned num_ch, input int unsigned stages,
                                        input int unsigned cnt_w);
    return (num_ch >= 1) && (cnt_w >= 1) && sync_stages_ok(stages);
  endfunction

endpackage

// File: rtl/pulse_hs_chan.sv
// One pulse-synchroniser channel: source-side toggle launcher with a saturating pending
// counter, destination-side edge detector, and the req/ack synchroniser chains between them.
`timescale 1ns/1ps
module pulse_hs_chan
  import cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic src_clk,
  input  logic src_rst_n,
  input  logic dst_clk,
  input  logic dst_rst_n,
  input  logic src_pulse,
  input  logic src_ovf_clr,
  output logic src_busy,
  output logic src_ovf,
  output logic dst_pulse
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Source domain
  logic                   req_tgl_q, req_tgl_d;
  logic [CNT_W-1:0]       pend_cnt_q, pend_cnt_d;
  logic                   ovf_q, ovf_d;
  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_d;
  logic                   src_idle;
  logic                   launch;
  logic                   drop;

  // Destination domain
  (* async_reg = "true" *) logic [SYNC_STAGES-1:0] req_sync_q;
  logic [SYNC_STAGES-1:0] req_sync_d;
  logic                   req_d_q, req_d_d;
  logic                   dst_pulse_q, dst_pulse_d;
  logic                   ack_tgl;

  assign ack_tgl = req_d_q;

  always_comb begin
    req_tgl_d  = req_tgl_q;
    pend_cnt_d = pend_cnt_q;
    ovf_d      = ovf_q;
    drop       = 1'b0;
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl};
    src_idle   = (req_tgl_q == ack_sync_q[SYNC_STAGES-1]);
    launch     = src_idle && ((pend_cnt_q != '0) || src_pulse);

    if (launch) begin
      req_tgl_d = ~req_tgl_q;
      // A pulse arriving alongside a queued launch takes the freed slot.
      if ((pend_cnt_q != '0) && !src_pulse) begin
        pend_cnt_d = pend_cnt_q - CntOne;
      end
    end else if (src_pulse) begin
      if (pend_cnt_q != CntMax) begin
        pend_cnt_d = pend_cnt_q + CntOne;
      end else begin
        drop = 1'b1;
      end
    end

    if (src_ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      req_tgl_q  <= 1'b0;
      pend_cnt_q <= '0;
      ovf_q      <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      req_tgl_q  <= req_tgl_d;
      pend_cnt_q <= pend_cnt_d;
      ovf_q      <= ovf_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign src_busy = !src_idle || (pend_cnt_q != '0);
  assign src_ovf  = ovf_q;

  always_comb begin
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
    req_d_d     = req_sync_q[SYNC_STAGES-1];
    dst_pulse_d = req_sync_q[SYNC_STAGES-1] ^ req_d_q;
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      req_sync_q  <= '0;
      req_d_q     <= 1'b0;
      dst_pulse_q <= 1'b0;
    end else begin
      req_sync_q  <= req_sync_d;
      req_d_q     <= req_d_d;
      dst_pulse_q <= dst_pulse_d;
    end
  end

  assign dst_pulse = dst_pulse_q;

endmodule

// File: rtl/pulse_hs_sync_multi.sv
// Multi-channel toggle-handshake pulse synchroniser with per-channel pending queue and
// sticky overflow flag.
`timescale 1ns/1ps
module pulse_hs_sync_multi
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic              src_clk,
  input  logic              src_rst_n,
  input  logic              dst_clk,
  input  logic              dst_rst_n,
  input  logic [NUM_CH-1:0] src_pulse,
  input  logic [NUM_CH-1:0] src_ovf_clr,
  output logic [NUM_CH-1:0] src_busy,
  output logic [NUM_CH-1:0] src_ovf,
  output logic [NUM_CH-1:0] dst_pulse
);

  if (!sync_params_ok(NUM_CH, SYNC_STAGES, CNT_W)) begin : g_param_err
    $error("pulse_hs_sync_multi: illegal NUM_CH/SYNC_STAGES/CNT_W");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_hs_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .src_clk     (src_clk),
      .src_rst_n   (src_rst_n),
      .dst_clk     (dst_clk),
      .dst_rst_n   (dst_rst_n),
      .src_pulse   (src_pulse[i]),
      .src_ovf_clr (src_ovf_clr[i]),
      .src_busy    (src_busy[i]),
      .src_ovf     (src_ovf[i]),
      .dst_pulse   (dst_pulse[i])
    );
  end

endmodule

// File: tb/tb_pulse_hs_sync_multi.sv
// Bench for pulse_hs_sync_multi: directed queue/overflow cases plus randomized traffic
// against an event-count model, across several clock ratios and a combined reset.
`timescale 1ns/1ps
module tb_pulse_hs_sync_multi;

  localparam int unsigned NCh = 2;
  localparam int unsigned Ss  = 2;
  localparam int unsigned Cw  = 2;
  localparam int unsigned QueueCap = (1 << Cw) - 1;

  logic src_clk = 1'b0;
  logic dst_clk = 1'b0;
  logic src_rst_n = 1'b0;
  logic dst_rst_n = 1'b0;
  logic [NCh-1:0] src_pulse = '0;
  logic [NCh-1:0] src_ovf_clr = '0;
  logic [NCh-1:0] src_busy;
  logic [NCh-1:0] src_ovf;
  logic [NCh-1:0] dst_pulse;

  realtime src_half = 5.0;
  realtime dst_half = 13.5;

  int n_cmp = 0;
  int n_err = 0;
  int dlv [NCh];
  logic [NCh-1:0] prev_pulse = '0;

  pulse_hs_sync_multi #(
    .NUM_CH      (NCh),
    .SYNC_STAGES (Ss),
    .CNT_W       (Cw)
  ) dut (
    .src_clk     (src_clk),
    .src_rst_n   (src_rst_n),
    .dst_clk     (dst_clk),
    .dst_rst_n   (dst_rst_n),
    .src_pulse   (src_pulse),
    .src_ovf_clr (src_ovf_clr),
    .src_busy    (src_busy),
    .src_ovf     (src_ovf),
    .dst_pulse   (dst_pulse)
  );

  initial forever #(src_half) src_clk = ~src_clk;
  initial forever #(dst_half) dst_clk = ~dst_clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Delivery monitor: counts dst pulses and flags any pulse wider than one cycle.
  initial begin
    for (int ch = 0; ch < NCh; ch++) dlv[ch] = 0;
    forever begin
      @(posedge dst_clk);
      #1;
      for (int ch = 0; ch < NCh; ch++) begin
        if (dst_pulse[ch]) begin
          dlv[ch]++;
          check_eq($sformatf("dst_width_ch%0d", ch), int'(prev_pulse[ch]), 0);
        end
      end
      prev_pulse = dst_pulse;
    end
  end

  // Called 1 time unit after a src posedge; applies inputs for exactly one src cycle.
  task automatic src_step(input logic [NCh-1:0] p, input logic [NCh-1:0] c);
    src_pulse   = p;
    src_ovf_clr = c;
    @(posedge src_clk);
    #1;
    src_pulse   = '0;
    src_ovf_clr = '0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int i;
    i = 0;
    while (src_busy != '0 && i < limit) begin
      src_step('0, '0);
      i++;
    end
    // Let a final in-flight dst pulse be counted before callers compare totals.
    repeat (2) @(posedge dst_clk);
    @(posedge src_clk);
    #1;
    check_eq({tag, "_idle"}, int'(src_busy), 0);
  endtask

  task automatic run_random(input string tag, input int cycles);
    int sent [NCh];
    int base [NCh];
    logic [NCh-1:0] p;
    for (int ch = 0; ch < NCh; ch++) begin
      sent[ch] = 0;
      base[ch] = dlv[ch];
    end
    for (int i = 0; i < cycles; i++) begin
      p = '0;
      for (int ch = 0; ch < NCh; ch++) begin
        // At most one delivered-but-unacked event can hide in the in-flight slot, so keeping
        // the outstanding count at or below QueueCap-1 before a pulse guarantees no drop.
        if ($urandom_range(0, 2) == 0 &&
            (sent[ch] - (dlv[ch] - base[ch])) <= int'(QueueCap) - 1) begin
          p[ch] = 1'b1;
          sent[ch]++;
        end
      end
      src_step(p, '0);
    end
    wait_idle(tag, 1000);
    for (int ch = 0; ch < NCh; ch++) begin
      check_eq($sformatf("%s_count_ch%0d", tag, ch), dlv[ch] - base[ch], sent[ch]);
    end
    check_eq({tag, "_ovf"}, int'(src_ovf), 0);
  endtask

  initial begin
    int b0, b1, n;
    bit seen;

    // Reset state
    repeat (3) @(posedge src_clk);
    #1;
    check_eq("rst_busy", int'(src_busy), 0);
    check_eq("rst_ovf", int'(src_ovf), 0);
    check_eq("rst_dst_pulse", int'(dst_pulse), 0);
    src_rst_n = 1'b1;
    dst_rst_n = 1'b1;
    src_step('0, '0);

    // T1: single pulse on ch0, latency from the launching src edge
    b0 = dlv[0];
    b1 = dlv[1];
    src_pulse = 2'b01;
    n = 0;
    seen = 1'b0;
    fork
      begin
        @(posedge src_clk);
        #1;
        src_pulse = '0;
        check_eq("t1_busy_after_launch", int'(src_busy[0]), 1);
      end
      begin
        @(posedge src_clk);
        while (!seen && n < 12) begin
          @(posedge dst_clk);
          n++;
          #1;
          if (dst_pulse[0]) seen = 1'b1;
        end
      end
    join
    check_eq("t1_latency_in_3_to_4", int'(n >= 3 && n <= 4), 1);
    wait_idle("t1", 200);
    check_eq("t1_count_ch0", dlv[0] - b0, 1);
    check_eq("t1_count_ch1", dlv[1] - b1, 0);

    // T2: three back-to-back pulses
    b0 = dlv[0];
    repeat (3) src_step(2'b01, '0);
    check_eq("t2_pend", int'(dut.g_ch[0].u_chan.pend_cnt_q), 2);
    wait_idle("t2", 300);
    check_eq("t2_count", dlv[0] - b0, 3);
    check_eq("t2_ovf", int'(src_ovf[0]), 0);

    // T3: five back-to-back pulses overflow a depth-3 queue
    b0 = dlv[0];
    repeat (5) src_step(2'b01, '0);
    check_eq("t3_ovf_set", int'(src_ovf[0]), 1);
    check_eq("t3_ovf_ch1", int'(src_ovf[1]), 0);
    wait_idle("t3", 300);
    check_eq("t3_count", dlv[0] - b0, 4);
    check_eq("t3_ovf_sticky", int'(src_ovf[0]), 1);
    src_step('0, 2'b01);
    check_eq("t3_ovf_clr", int'(src_ovf[0]), 0);

    // T4: clear coincident with a drop leaves ovf set
    b0 = dlv[0];
    repeat (5) src_step(2'b01, '0);
    src_step(2'b01, 2'b01);
    check_eq("t4_drop_beats_clr", int'(src_ovf[0]), 1);
    wait_idle("t4", 300);
    check_eq("t4_count", dlv[0] - b0, 4);
    src_step('0, 2'b01);
    check_eq("t4_ovf_clr", int'(src_ovf[0]), 0);

    // T5: pulse coincident with a queued launch at pend_cnt=1
    b0 = dlv[0];
    src_step(2'b01, '0);
    src_step(2'b01, '0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (dut.g_ch[0].u_chan.src_idle) seen = 1'b1;
      else src_step('0, '0);
    end
    check_eq("t5_idle_reached", int'(seen), 1);
    src_step(2'b01, '0);
    check_eq("t5_pend_held", int'(dut.g_ch[0].u_chan.pend_cnt_q), 1);
    wait_idle("t5", 300);
    check_eq("t5_count", dlv[0] - b0, 3);

    // T6: randomized traffic at several clock ratios
    run_random("rnd_base", 300);
    src_half = 5.0;
    dst_half = 25.0;
    run_random("rnd_1to5", 300);
    src_half = 25.0;
    dst_half = 5.0;
    run_random("rnd_5to1", 200);
    src_half = 5.0;
    dst_half = 13.5;
    src_step('0, '0);

    // T7: combined reset during in-flight transfers
    src_step(2'b11, '0);
    src_step(2'b11, '0);
    src_step('0, '0);
    src_rst_n = 1'b0;
    dst_rst_n = 1'b0;
    #1;
    check_eq("t7_rst_busy", int'(src_busy), 0);
    check_eq("t7_rst_ovf", int'(src_ovf), 0);
    check_eq("t7_rst_dst_pulse", int'(dst_pulse), 0);
    repeat (5) @(posedge src_clk);
    #1;
    src_rst_n = 1'b1;
    dst_rst_n = 1'b1;
    b0 = dlv[0];
    b1 = dlv[1];
    repeat (40) src_step('0, '0);
    check_eq("t7_no_spurious_ch0", dlv[0] - b0, 0);
    check_eq("t7_no_spurious_ch1", dlv[1] - b1, 0);
    check_eq("t7_busy_after", int'(src_busy), 0);
    src_step(2'b11, '0);
    src_step(2'b01, '0);
    wait_idle("t7", 300);
    check_eq("t7_post_ch0", dlv[0] - b0, 2);
    check_eq("t7_post_ch1", dlv[1] - b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2ms;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
